writeback_queue: RTL and testbench

Buffers register-file write requests from the pipeline's writeback sources and drains them, one per cycle, onto the single write port of `register_file`. It sits between the writeback stage and `register_file`. It drives that block's `write_reg`, `write_data` and `write_enable` inputs. An optional forwarding path returns queued-but-not-yet-written data to the decode stage's `rs`/`rt` lookups.

---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 34 +++
 rtl/writeback_queue.sv | 118 +++++++++++
 tb/tb_writeback_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback entry type used around
// the register file write port.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // "reg" is a keyword, so the destination field is named rd.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match lookup over the writeback queue: scans valid entries from
// head towards tail so the last match seen (nearest tail) wins.
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    ent_reg  [DEPTH],
  input  logic [DW-1:0]    ent_data [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    idx,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] pos;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    pos  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      // Register zero is hard-wired, so it never forwards.
      if (valid[pos] && (ent_reg[pos] == idx) && (idx != '0)) begin
        hit  = 1'b1;
        data = ent_data[pos];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback request FIFO draining one write per cycle into the register file.
// Forwarding of queued data to decode is built only with WB_QUEUE_FWD_EN.
module writeback_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_reg,
  input  logic [DW-1:0]            req_data,
  input  logic                     hold,
  output logic [AW-1:0]            write_reg,
  output logic [DW-1:0]            write_data,
  output logic                     write_enable,
  input  logic [AW-1:0]            rs,
  input  logic [AW-1:0]            rt,
  output logic                     fwd_hit_1,
  output logic                     fwd_hit_2,
  output logic [DW-1:0]            fwd_data_1,
  output logic [DW-1:0]            fwd_data_2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_reg  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign empty        = (cnt == '0);
  assign req_ready    = (cnt != CW'(DEPTH));
  assign write_enable = !empty && !hold;
  assign write_reg    = empty ? '0 : mem_reg[head];
  assign write_data   = empty ? '0 : mem_data[head];
  assign count        = cnt;

  // Writes to r0 complete the handshake but are dropped.
  assign push = req_valid && req_ready && (req_reg != '0);
  assign pop  = write_enable;

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[tail]  <= req_reg;
      mem_data[tail] <= req_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef WB_QUEUE_FWD_EN
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = ({1'b0, off} < cnt);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_rs (
    .ent_reg  (mem_reg),
    .ent_data (mem_data),
    .valid    (valid),
    .head     (head),
    .idx      (rs),
    .hit      (fwd_hit_1),
    .data     (fwd_data_1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_rt (
    .ent_reg  (mem_reg),
    .ent_data (mem_data),
    .valid    (valid),
    .head     (head),
    .idx      (rt),
    .hit      (fwd_hit_2),
    .data     (fwd_data_2)
  );
`else
  logic unused_lookup;
  assign unused_lookup = ^{rs, rt};
  assign fwd_hit_1  = 1'b0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: expected writes go into a scoreboard
// queue, a negedge monitor checks each issued write against it.
module tb_writeback_queue;
  import mips_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_reg;
  logic [31:0]   req_data;
  logic          hold;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic          write_enable;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          fwd_hit_1;
  logic          fwd_hit_2;
  logic [31:0]   fwd_data_1;
  logic [31:0]   fwd_data_2;
  logic [2:0]    count;
  logic          empty;

  int n_vec = 0;
  int n_err = 0;
  wb_entry_t exp_q[$];
  logic [31:0] rf [32];

  writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .hold         (hold),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .rs           (rs),
    .rt           (rt),
    .fwd_hit_1    (fwd_hit_1),
    .fwd_hit_2    (fwd_hit_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2),
    .count        (count),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  // Register file model: always accepts the write port.
  always @(posedge clock) begin
    if (write_enable) rf[write_reg] <= write_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issued write must match the oldest expected entry.
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge clock);
      if (!reset && write_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, write_reg, write_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_reg", 64'(write_reg), 64'(e.rd));
          check("write_data", 64'(write_data), 64'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_entry_t e;
    req_valid = 1'b1;
    req_reg   = r;
    req_data  = d;
    if (r != 5'd0) begin
      e.rd   = r;
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_fwd(input string name, input logic hit_a, input logic [31:0] dat_a,
                           input logic hit_b, input logic [31:0] dat_b);
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
`ifdef WB_QUEUE_FWD_EN
    eh1 = hit_a; ed1 = dat_a; eh2 = hit_b; ed2 = dat_b;
`else
    eh1 = 1'b0; ed1 = 32'd0; eh2 = 1'b0; ed2 = 32'd0;
    if (hit_a || hit_b || (dat_a != 32'd0) || (dat_b != 32'd0)) eh1 = 1'b0;
`endif
    check({name, "_hit1"},  64'(fwd_hit_1),  64'(eh1));
    check({name, "_data1"}, 64'(fwd_data_1), 64'(ed1));
    check({name, "_hit2"},  64'(fwd_hit_2),  64'(eh2));
    check({name, "_data2"}, 64'(fwd_data_2), 64'(ed2));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_reg = '0; req_data = '0;
    hold = 1'b0; rs = 5'h10; rt = 5'h11;
    repeat (2) @(posedge clock);
    #1;
    check("rst_we",    64'(write_enable), 64'd0);
    check("rst_empty", 64'(empty),        64'd1);
    check("rst_ready", 64'(req_ready),    64'd1);
    check("rst_count", 64'(count),        64'd0);
    check("rst_wreg",  64'(write_reg),    64'd0);
    check("rst_wdata", 64'(write_data),   64'd0);
    check_fwd("rst", 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    step();
    check("idle_we", 64'(write_enable), 64'd0);

    // Single write, one-cycle latency to the write port.
    push(5'h10, 32'hFFFF_FFFF);
    check("single_count", 64'(count),        64'd1);
    check("single_we",    64'(write_enable), 64'd1);
    check("single_wreg",  64'(write_reg),    64'h10);
    step();
    check("single_rf16",  64'(rf[16]),       64'hFFFF_FFFF);
    check("single_empty", 64'(empty),        64'd1);

    // Fill under hold, refuse a fifth request, then drain in order.
    hold = 1'b1;
    push(5'h11, 32'hFFFF_EEEE);
    push(5'h12, 32'hEEEE_DDDD);
    push(5'h13, 32'hDDDD_CCCC);
    push(5'h14, 32'hCCCC_BBBB);
    check("fill_count", 64'(count),        64'd4);
    check("fill_ready", 64'(req_ready),    64'd0);
    check("fill_we",    64'(write_enable), 64'd0);
    req_valid = 1'b1; req_reg = 5'h15; req_data = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    check("full_reject_count", 64'(count), 64'd4);
    hold = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      step();
      check("drain_count", 64'(count), 64'(i));
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_rf20",  64'(rf[20]), 64'hCCCC_BBBB);

    // Youngest match wins; entry stays forwardable while on the write port.
    hold = 1'b1;
    push(5'h12, 32'hAAAA_0001);
    push(5'h12, 32'hAAAA_0002);
    rs = 5'h12; rt = 5'h07;
    #1;
    check_fwd("fwd_prio", 1'b1, 32'hAAAA_0002, 1'b0, 32'd0);
    rt = 5'h12;
    #1;
    check_fwd("fwd_both", 1'b1, 32'hAAAA_0002, 1'b1, 32'hAAAA_0002);
    hold = 1'b0;
    step();
    check("fwd_pop_count", 64'(count), 64'd1);
    check_fwd("fwd_head", 1'b1, 32'hAAAA_0002, 1'b1, 32'hAAAA_0002);
    step();
    check_fwd("fwd_gone", 1'b0, 32'd0, 1'b0, 32'd0);

    // r0 request: accepted, not stored, never forwarded.
    check("r0_ready", 64'(req_ready), 64'd1);
    push(5'd0, 32'hDEAD_BEEF);
    check("r0_count", 64'(count),        64'd0);
    check("r0_empty", 64'(empty),        64'd1);
    check("r0_we",    64'(write_enable), 64'd0);
    rs = 5'd0; rt = 5'd0;
    #1;
    check_fwd("r0_fwd", 1'b0, 32'd0, 1'b0, 32'd0);

    // Streaming at count=2 across pointer wrap, then async reset mid-stream.
    hold = 1'b1;
    push(5'h01, 32'h4000_0001);
    push(5'h02, 32'h4000_0002);
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(5'(i + 3), 32'h5000_0000 + 32'(i));
      check("stream_count", 64'(count), 64'd2);
    end
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("areset_empty", 64'(empty),        64'd1);
    check("areset_we",    64'(write_enable), 64'd0);
    check("areset_count", 64'(count),        64'd0);
    check("areset_ready", 64'(req_ready),    64'd1);
    step();
    reset = 1'b0;
    repeat (3) step();
    check("post_empty", 64'(empty), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
